// File: rtl/router_input_arbiter.sv
// rtl/router_input_arbiter.sv - packet-granular round-robin input arbiter with 2-entry skid output
// Optional ARB_BURST_EN: keep the grant for up to MAX_PACKAGES back-to-back packets.
module router_input_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int REN          = 5,
    parameter int CS           = 2,
    parameter int MAX_PACKAGES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REN*DATA_WIDTH-1:0] in_tdata,
    input  logic [REN-1:0]            in_tvalid,
    input  logic [REN-1:0]            in_tlast,
    output logic [REN-1:0]            in_tready,
    output logic [DATA_WIDTH-1:0]     out_tdata,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    output logic [$clog2(REN)-1:0]    out_tid,
    input  logic                      out_tready
);
    localparam int PW = $clog2(REN);

    if (2 * CS > DATA_WIDTH || REN < 2 || MAX_PACKAGES < 1) begin : g_bad_cfg
        $error("router_input_arbiter: header does not fit the flit or bad port/burst count");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         rr_ptr, rr_nxt;
    logic [PW-1:0]         grant, grant_nxt;
    logic [PW-1:0]         winner, idx;
    logic                  found;
    logic [DATA_WIDTH-1:0] port_data [REN];

    logic [DATA_WIDTH-1:0] mem_data [2];
    logic                  mem_last [2];
    logic [PW-1:0]         mem_tid  [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            skid_cnt;
    logic                  skid_full, push, pop;

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_PACKAGES) + 1;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
`endif

    for (genvar p = 0; p < REN; p++) begin : g_port
        assign port_data[p] = in_tdata[p*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting at rr_ptr, wrapping modulo REN.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < REN; i++) begin
            idx = PW'((int'(rr_ptr) + i) % REN);
            if (!found && in_tvalid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign skid_full = (skid_cnt == 2'd2);
    assign push      = (state == BUSY) && in_tvalid[grant] && !skid_full;
    assign pop       = out_tvalid && out_tready;

    always_comb begin
        in_tready = '0;
        if (state == BUSY && !skid_full) begin
            in_tready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
`ifdef ARB_BURST_EN
        cnt_nxt   = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (push && in_tlast[grant]) begin
`ifdef ARB_BURST_EN
                    if (in_tvalid[grant] && (burst_cnt + 1'b1) < CNT_W'(MAX_PACKAGES)) begin
                        cnt_nxt = burst_cnt + 1'b1;
                    end else begin
                        cnt_nxt   = '0;
                        rr_nxt    = (grant == PW'(REN - 1)) ? '0 : grant + 1'b1;
                        state_nxt = IDLE;
                    end
`else
                    rr_nxt    = (grant == PW'(REN - 1)) ? '0 : grant + 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
`ifdef ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            grant  <= grant_nxt;
`ifdef ARB_BURST_EN
            burst_cnt <= cnt_nxt;
`endif
        end
    end

    // Skid FIFO: entries are cleared on reset so the idle output reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
                mem_tid[i]  <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= port_data[grant];
                mem_last[wr_ptr] <= in_tlast[grant];
                mem_tid[wr_ptr]  <= grant;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign out_tvalid = (skid_cnt != 2'd0);
    assign out_tdata  = mem_data[rd_ptr];
    assign out_tlast  = out_tvalid && mem_last[rd_ptr];
    assign out_tid    = mem_tid[rd_ptr];

endmodule

// File: tb/tb_router_input_arbiter.sv
// tb/tb_router_input_arbiter.sv - scoreboard bench for router_input_arbiter
module tb_router_input_arbiter;
    localparam int DW  = 32;
    localparam int REN = 5;
    localparam int PW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REN*DW-1:0] in_tdata;
    logic [REN-1:0]    in_tvalid, in_tlast, in_tready;
    logic [DW-1:0]     out_tdata;
    logic              out_tvalid, out_tlast, out_tready;
    logic [PW-1:0]     out_tid;

    always #5 clk = ~clk;

    router_input_arbiter #(
        .DATA_WIDTH(DW), .REN(REN), .CS(2), .MAX_PACKAGES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .out_tid(out_tid), .out_tready(out_tready)
    );

    logic [DW:0]      src_q [REN][$];
    logic [PW+DW:0]   exp_q [$];
    logic [REN-1:0]   hs_pend;
    logic             stall;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_src(input int p, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) src_q[p].push_back({(i == n - 1), base + DW'(i)});
    endtask

    task automatic expect_pkt(input int p, input int n, input logic [DW-1:0] base);
        logic [PW-1:0] tid;
        tid = PW'(p);
        for (int i = 0; i < n; i++) exp_q.push_back({tid, (i == n - 1), base + DW'(i)});
    endtask

    task automatic send(input int p, input int n, input logic [DW-1:0] base);
        load_src(p, n, base);
        expect_pkt(p, n, base);
    endtask

    // One clock: retire accepted input flits, drive sources, score output beats.
    task automatic cycle();
        @(negedge clk);
        for (int p = 0; p < REN; p++) begin
            if (hs_pend[p]) void'(src_q[p].pop_front());
        end
        out_tready = !stall;
        for (int p = 0; p < REN; p++) begin
            if (src_q[p].size() > 0) begin
                {in_tlast[p], in_tdata[p*DW +: DW]} = src_q[p][0];
                in_tvalid[p] = 1'b1;
            end else begin
                in_tvalid[p] = 1'b0;
                in_tlast[p]  = 1'b0;
            end
        end
        hs_pend = in_tvalid & in_tready;
        if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) check("extra_flit", {out_tid, out_tlast, out_tdata}, '0);
            else check("flit", {out_tid, out_tlast, out_tdata}, exp_q.pop_front());
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) cycle();
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        in_tdata   = '0;
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        hs_pend    = '0;

        // Reset with every port requesting; port 0 must win first after release.
        for (int p = 0; p < REN; p++) send(p, 1, DW'(32'h100 * (p + 1)));
        repeat (3) cycle();
        check("rst_in_tready", in_tready, 0);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tlast", out_tlast, 0);
        check("rst_out_tdata", out_tdata, 0);
        check("rst_out_tid", out_tid, 0);
        rst_n = 1'b1;
        cycle();
        check("first_grant", in_tready, 5'b00001);
        drain(50);

        // Round robin across ports 1, 3, 4 with 2-flit packets.
        send(1, 2, 32'h10);
        send(3, 2, 32'h30);
        send(4, 2, 32'h40);
        send(1, 2, 32'h18);
        drain(60);

        // Port 0 arrives mid-packet of port 2 and must wait for its tlast.
        send(2, 4, 32'hA0);
        cycle();
        cycle();
        send(0, 2, 32'hB0);
        drain(60);

        // Backpressure mid-packet: skid fills, head held stable.
        send(1, 6, 32'hC0);
        repeat (3) cycle();
        stall = 1'b1;
        cycle();
        check("stall_valid", out_tvalid, 1);
        check("stall_head", out_tdata, exp_q[0][DW-1:0]);
        repeat (4) cycle();
        check("stall_full_ready", in_tready, 0);
        check("stall_hold", out_tdata, exp_q[0][DW-1:0]);
        check("stall_hold_tid", out_tid, exp_q[0][PW+DW:DW+1]);
        stall = 1'b0;
        drain(60);

        // Port 3 leaves rr_ptr at 4; ports 0 and 4 then request together.
        send(3, 1, 32'hD0);
        drain(30);
        send(4, 1, 32'hF0);
        send(0, 1, 32'hE0);
        drain(30);

        // Port 1 streams six 1-flit packets while port 2 waits.
        for (int k = 0; k < 6; k++) load_src(1, 1, DW'(32'h60 + k));
        load_src(2, 1, 32'h70);
`ifdef ARB_BURST_EN
        for (int k = 0; k < 4; k++) expect_pkt(1, 1, DW'(32'h60 + k));
        expect_pkt(2, 1, 32'h70);
        for (int k = 4; k < 6; k++) expect_pkt(1, 1, DW'(32'h60 + k));
`else
        expect_pkt(1, 1, 32'h60);
        expect_pkt(2, 1, 32'h70);
        for (int k = 1; k < 6; k++) expect_pkt(1, 1, DW'(32'h60 + k));
`endif
        drain(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
